// File: rtl/scoreboard_button_ctrl.sv
// Button front end for the two-digit BCD scoreboard counter.
// Each raw button goes through a 2-flop synchroniser and then a debouncer.
// A two-state FSM (IDLE/HOLD) turns debounced presses into single-cycle,
// mutually exclusive inc/dec/erase pulses. Priority is erase > inc > dec.
// Optional build macro AUTOREPEAT_EN: while up/down is held, extra pulses
// follow after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module scoreboard_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic up_btn_i,
  input  logic down_btn_i,
  input  logic clear_btn_i,
  output logic inc_o,
  output logic dec_o,
  output logic erase_o,
  output logic busy_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Button bit order everywhere: [0]=up, [1]=down, [2]=clear
  logic [2:0] raw_btn;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] db_lvl;
  logic [2:0] db_prev_q;
  logic [2:0] press;
  logic [2:0] win;

  state_t     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic       held;
  logic       rep_fire;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       erase_q, erase_d;

  assign raw_btn = {clear_btn_i, down_btn_i, up_btn_i};

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_btn;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_db
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            lvl_q, lvl_d;

      // Count consecutive disagreeing samples and flip the level on the last one
      always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        if (sync2_q[gi] == lvl_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_d = '0;
          lvl_d = ~lvl_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Debounce counter and debounced level registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          lvl_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          lvl_q <= lvl_d;
        end
      end

      assign db_lvl[gi] = lvl_q;
    end
  endgenerate

  // Delayed copy of the debounced levels for rising-edge (press) detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev_q <= '0;
    end else begin
      db_prev_q <= db_lvl;
    end
  end

  assign press = db_lvl & ~db_prev_q;
  assign win   = press[2] ? 3'b100 :
                 press[0] ? 3'b001 :
                 press[1] ? 3'b010 : 3'b000;
  assign held  = |(db_lvl & owner_q);

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_active;

  // Only a held up/down button repeats; the owner dropping ends the run
  assign rep_active = (state_q == HOLD) && held && !owner_q[2];
  assign rep_fire   = rep_active &&
                      (rep_first_q ? (rep_cnt_q == DELAY_LAST) : (rep_cnt_q == PERIOD_LAST));

  // Repeat counter: idle at zero outside an active hold, restart after each pulse
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (!rep_active) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_fire) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d   = rep_cnt_q + 1'b1;
    end
  end

  // Repeat counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // FSM state, owning button and registered command outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      erase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      erase_q <= erase_d;
    end
  end

  // Next state: accept one press in IDLE, leave HOLD once the owner is released
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (|press) begin
          state_d = HOLD;
          owner_d = win;
        end
      end
      HOLD: begin
        if (!held) begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  // Command decode: press winner in IDLE, repeat pulses of the owner in HOLD
  always_comb begin
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    erase_d = 1'b0;
    if (state_q == IDLE) begin
      inc_d   = win[0];
      dec_d   = win[1];
      erase_d = win[2];
    end else if (rep_fire) begin
      inc_d   = owner_q[0];
      dec_d   = owner_q[1];
    end
  end

  assign inc_o   = inc_q;
  assign dec_o   = dec_q;
  assign erase_o = erase_q;
  assign busy_o  = (state_q == HOLD);

endmodule

// File: doc/scoreboard_button_ctrl.md
Name: scoreboard_button_ctrl

Overview:
Front-end controller for the two-digit BCD scoreboard counter. Takes three raw, bouncy, asynchronous push-buttons (up, down, clear). It synchronises and debounces them, then arbitrates between them. Its output is single-cycle, mutually exclusive inc/dec/erase command pulses that drive the counter's inc_i/dec_i/erase_i directly, on the same clock.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronised samples required before a debounced level changes (5 ms @ 50 MHz); min 1.
REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat pulse (AUTOREPEAT_EN only).
REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses (AUTOREPEAT_EN only); min 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
up_btn_i  input  1  raw up button, active-high, asynchronous to clk.
down_btn_i  input  1  raw down button, active-high, asynchronous.
clear_btn_i  input  1  raw clear button, active-high, asynchronous.
inc_o  output  1  one-cycle increment command to counter.
dec_o  output  1  one-cycle decrement command to counter.
erase_o  output  1  one-cycle erase command to counter.
busy_o  output  1  high while a press is being held (FSM not IDLE).

Behaviour:
- Reset is asynchronous and active-high, applied directly to every flop. Values while rst=1: sync flops 0, debounced levels 0, debounce counters 0, FSM IDLE, inc_o=dec_o=erase_o=busy_o=0. Reset mid-press discards the press. After release of rst, a button still held needs a full debounce qualification and then produces a fresh press event.
- Synchroniser: each raw input passes through a 2-flop synchroniser.
- Debounce, per button: width-$clog2(DEBOUNCE_CYCLES+1) counter.
  - When the sync output equals the debounced level, the counter clears to 0.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the debounced level.
- Press event: debounced level 0->1, detected against a registered copy of the debounced level.
- FSM states: IDLE, HOLD.
  - IDLE: on one or more press events in a cycle, register exactly one command (priority erase > inc > dec), record which button won, go to HOLD.
  - HOLD: stay while the recorded button's debounced level is 1; go to IDLE the cycle after it debounces to 0.
  - Press events from other buttons during HOLD are ignored and are not queued.
  - Returning to IDLE while another button is still held produces no command. That button must be released and pressed again.
- Outputs are registered.
  - The command pulse is high for exactly one cycle, in the cycle after the press event.
  - Latency from the first clk edge sampling a stable raw level to the pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
  - At most one of inc_o/dec_o/erase_o is ever high.
- busy_o=1 exactly in HOLD.
- No counter wrap concerns: the debounce counter saturates by clearing, and the repeat counter is cleared on entry to HOLD.

Optional Feature:
AUTOREPEAT_EN
- Defined: in HOLD with the recorded button up or down, a repeat counter (width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)) runs.
  - After REPEAT_DELAY cycles in HOLD, one extra inc_o/dec_o pulse is issued.
  - A further pulse follows every REPEAT_PERIOD cycles while held.
  - Clear never repeats.
  - The counter clears on entering HOLD and on leaving HOLD. A release exactly on a repeat boundary suppresses that pulse.
- Undefined: exactly one pulse per press; repeat logic is absent.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5):
- Hold rst=1, then toggle all buttons -> all outputs stay 0 and busy_o=0. Release rst with up held -> a single inc_o pulse 7 cycles later.
- up_btn_i rises cleanly and is held 50 cycles, then released (macro off) -> exactly one inc_o pulse, 7 cycles after the first sampling edge. busy_o stays high until 7 cycles after release.
- up_btn_i bounces 1-0-1-0 (1-3 cycles each) then stable 1 -> exactly one inc_o pulse. A 3-cycle glitch alone -> no pulse.
- clear and up rise in the same cycle -> erase_o only. up held after clear released, no re-press -> no inc_o.
- Hold down (macro on) for 40 cycles after the first dec_o -> dec_o pulses at HOLD+20, +25, +30, +35, +40. Clear held for 40 cycles -> a single erase_o.
- Assert rst for 1 cycle mid-HOLD -> outputs 0 at once, FSM IDLE. The held button re-qualifies and produces one new pulse.
